// File: rtl/dram_region_loader.sv
// ---------------------------------------------------------------------------
// dram_region_loader
//
// Streams up to N_REGIONS DRAM address ranges into on-chip buffers. Regions
// are visited in index order; each enabled region reads DRAM words from its
// start address to its finish address (inclusive). It packs P consecutive
// words into one wide destination write, where P is the region's pack factor
// clamped to 1..MAX_PACK.
//
// Ports
//   clk_i                 rising-edge clock
//   general_rst_n_i       synchronous active-low reset
//   start_i               starts a pass (IDLE only)
//   region_en_i           per-region enable, captured at start
//   region_start_addr_i   per-region first DRAM word address (not latched)
//   region_finish_addr_i  per-region last DRAM word address (not latched)
//   region_pack_i         per-region DRAM words per destination entry
//   dram_rd_req_o/addr_o  read request, held until dram_rd_ack_i
//   dram_rd_ack_i         request accepted
//   dram_rd_valid_i/data_i read data return (only honoured while waiting)
//   wr_en_o/region_o/addr_o/data_o  destination write, one cycle per entry
//   busy_o, done_o        pass in progress / one-cycle end-of-pass pulse
//   overflow_o            sticky: a region hit the top destination address
//   cfg_err_o             sticky: a region had finish < start
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dram_region_loader #(
    parameter int DRAM_ADDR_WIDTH    = 18,
    parameter int DATA_IN_DRAM_WIDTH = 32,
    parameter int N_REGIONS          = 4,
    parameter int REGION_IDX_WIDTH   = 2,
    parameter int DST_ADDR_WIDTH     = 16,
    parameter int MAX_PACK           = 4,
    parameter int PACK_WIDTH         = 3
) (
    input  logic                                    clk_i,
    input  logic                                    general_rst_n_i,
    input  logic                                    start_i,
    input  logic [N_REGIONS-1:0]                    region_en_i,
    input  logic [N_REGIONS*DRAM_ADDR_WIDTH-1:0]    region_start_addr_i,
    input  logic [N_REGIONS*DRAM_ADDR_WIDTH-1:0]    region_finish_addr_i,
    input  logic [N_REGIONS*PACK_WIDTH-1:0]         region_pack_i,
    output logic                                    dram_rd_req_o,
    output logic [DRAM_ADDR_WIDTH-1:0]              dram_rd_addr_o,
    input  logic                                    dram_rd_ack_i,
    input  logic                                    dram_rd_valid_i,
    input  logic [DATA_IN_DRAM_WIDTH-1:0]           dram_rd_data_i,
    output logic                                    wr_en_o,
    output logic [REGION_IDX_WIDTH-1:0]             wr_region_o,
    output logic [DST_ADDR_WIDTH-1:0]               wr_addr_o,
    output logic [MAX_PACK*DATA_IN_DRAM_WIDTH-1:0]  wr_data_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    overflow_o,
    output logic                                    cfg_err_o
);

    // One extra pointer bit so "past the last region" is representable.
    localparam int                    PTR_W     = REGION_IDX_WIDTH + 1;
    localparam int                    DW        = DATA_IN_DRAM_WIDTH;
    localparam logic [PTR_W-1:0]      PTR_END   = PTR_W'(N_REGIONS);
    localparam logic [PACK_WIDTH-1:0] PACK_MAX  = PACK_WIDTH'(MAX_PACK);
    localparam logic [PACK_WIDTH-1:0] PACK_ONE  = PACK_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic [N_REGIONS-1:0]           en_q, en_d;
    logic [DRAM_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DST_ADDR_WIDTH-1:0]      dst_q, dst_d;
    logic [PACK_WIDTH-1:0]          k_q, k_d;
    logic [MAX_PACK*DW-1:0]         pack_q, pack_d;
    logic                           ovf_q, ovf_d;
    logic                           cfg_q, cfg_d;
    logic                           req_q, wr_en_q, busy_q, done_q;

    logic                           cur_en_s;
    logic [DRAM_ADDR_WIDTH-1:0]     cur_start_s;
    logic [DRAM_ADDR_WIDTH-1:0]     cur_finish_s;
    logic [PACK_WIDTH-1:0]          cur_pack_raw_s;
    logic [PACK_WIDTH-1:0]          eff_pack_s;
    logic                           at_finish_s;
    logic                           slot_last_s;

    // Select the configuration of the region under the pointer (zero when past the end).
    always_comb begin
        cur_en_s       = 1'b0;
        cur_start_s    = '0;
        cur_finish_s   = '0;
        cur_pack_raw_s = '0;
        for (int r = 0; r < N_REGIONS; r++) begin
            cur_en_s       = cur_en_s | ((ptr_q == PTR_W'(r)) & en_q[r]);
            cur_start_s    = cur_start_s | ((ptr_q == PTR_W'(r)) ?
                             region_start_addr_i[r*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH] : '0);
            cur_finish_s   = cur_finish_s | ((ptr_q == PTR_W'(r)) ?
                             region_finish_addr_i[r*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH] : '0);
            cur_pack_raw_s = cur_pack_raw_s | ((ptr_q == PTR_W'(r)) ?
                             region_pack_i[r*PACK_WIDTH +: PACK_WIDTH] : '0);
        end
    end

    // Clamp the pack factor to 1..MAX_PACK.
    always_comb begin
        if (cur_pack_raw_s == '0) begin
            eff_pack_s = PACK_ONE;
        end else if (cur_pack_raw_s > PACK_MAX) begin
            eff_pack_s = PACK_MAX;
        end else begin
            eff_pack_s = cur_pack_raw_s;
        end
    end

    assign at_finish_s = (addr_q == cur_finish_s);
    assign slot_last_s = (k_q == (eff_pack_s - PACK_ONE));

    // Next-state and datapath update for the loader FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        k_d     = k_q;
        pack_d  = pack_q;
        ovf_d   = ovf_q;
        cfg_d   = cfg_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    en_d    = region_en_i;
                    ovf_d   = 1'b0;
                    cfg_d   = 1'b0;
                    ptr_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                if (ptr_q >= PTR_END) begin
                    state_d = S_DONE;
                end else if (!cur_en_s) begin
                    ptr_d = ptr_q + PTR_W'(1);
                end else if (cur_finish_s < cur_start_s) begin
                    cfg_d = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                end else begin
                    addr_d  = cur_start_s;
                    dst_d   = '0;
                    k_d     = '0;
                    pack_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dram_rd_ack_i) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (dram_rd_valid_i) begin
                    for (int s = 0; s < MAX_PACK; s++) begin
                        pack_d[s*DW +: DW] = (k_q == PACK_WIDTH'(s)) ?
                                             dram_rd_data_i : pack_q[s*DW +: DW];
                    end
                    // The finish test comes before any increment, so the
                    // address counter can never wrap past the top of DRAM.
                    if (slot_last_s || at_finish_s) begin
                        state_d = S_WRITE;
                    end else begin
                        k_d     = k_q + PACK_ONE;
                        addr_d  = addr_q + DRAM_ADDR_WIDTH'(1);
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                pack_d = '0;
                k_d    = '0;
                if (at_finish_s) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = S_SELECT;
                end else if (dst_q == '1) begin
                    ovf_d   = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                    state_d = S_SELECT;
                end else begin
                    dst_d   = dst_q + DST_ADDR_WIDTH'(1);
                    addr_d  = addr_q + DRAM_ADDR_WIDTH'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; strobes are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (!general_rst_n_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            dst_q   <= '0;
            k_q     <= '0;
            pack_q  <= '0;
            ovf_q   <= 1'b0;
            cfg_q   <= 1'b0;
            req_q   <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            k_q     <= k_d;
            pack_q  <= pack_d;
            ovf_q   <= ovf_d;
            cfg_q   <= cfg_d;
            req_q   <= (state_d == S_REQ);
            wr_en_q <= (state_d == S_WRITE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign dram_rd_req_o  = req_q;
    assign dram_rd_addr_o = addr_q;
    assign wr_en_o        = wr_en_q;
    assign wr_region_o    = ptr_q[REGION_IDX_WIDTH-1:0];
    assign wr_addr_o      = dst_q;
    assign wr_data_o      = pack_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign overflow_o     = ovf_q;
    assign cfg_err_o      = cfg_q;

endmodule

// File: tb/tb_dram_region_loader.sv
// ---------------------------------------------------------------------------
// tb_dram_region_loader
//
// Self-checking bench for dram_region_loader with a 2-bit destination
// address so that overflow is easy to reach. A DRAM responder answers
// requests with programmable or random ack/valid delays. Expected writes
// come from a region-level model: each enabled region is cut into
// ceil(words/P) entries, capped at 2^DST_ADDR_WIDTH.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dram_region_loader;

    localparam int DAW  = 18;
    localparam int DW   = 32;
    localparam int NR   = 4;
    localparam int IDXW = 2;
    localparam int DSTW = 2;
    localparam int MP   = 4;
    localparam int PW   = 3;

    logic                 clk;
    logic                 general_rst_n_i;
    logic                 start_i;
    logic [NR-1:0]        region_en_i;
    logic [NR*DAW-1:0]    region_start_addr_i;
    logic [NR*DAW-1:0]    region_finish_addr_i;
    logic [NR*PW-1:0]     region_pack_i;
    logic                 dram_rd_req_o;
    logic [DAW-1:0]       dram_rd_addr_o;
    logic                 dram_rd_ack_i;
    logic                 dram_rd_valid_i;
    logic [DW-1:0]        dram_rd_data_i;
    logic                 wr_en_o;
    logic [IDXW-1:0]      wr_region_o;
    logic [DSTW-1:0]      wr_addr_o;
    logic [MP*DW-1:0]     wr_data_o;
    logic                 busy_o, done_o, overflow_o, cfg_err_o;

    dram_region_loader #(
        .DRAM_ADDR_WIDTH(DAW), .DATA_IN_DRAM_WIDTH(DW), .N_REGIONS(NR),
        .REGION_IDX_WIDTH(IDXW), .DST_ADDR_WIDTH(DSTW), .MAX_PACK(MP),
        .PACK_WIDTH(PW)
    ) dut (
        .clk_i(clk), .general_rst_n_i(general_rst_n_i), .start_i(start_i),
        .region_en_i(region_en_i), .region_start_addr_i(region_start_addr_i),
        .region_finish_addr_i(region_finish_addr_i), .region_pack_i(region_pack_i),
        .dram_rd_req_o(dram_rd_req_o), .dram_rd_addr_o(dram_rd_addr_o),
        .dram_rd_ack_i(dram_rd_ack_i), .dram_rd_valid_i(dram_rd_valid_i),
        .dram_rd_data_i(dram_rd_data_i), .wr_en_o(wr_en_o), .wr_region_o(wr_region_o),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .cfg_err_o(cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [NR-1:0]       en;
        logic [NR-1:0][DAW-1:0] st;
        logic [NR-1:0][DAW-1:0] fin;
        logic [NR-1:0][PW-1:0]  pk;
        int                  ack_dly;
        int                  val_dly;
        bit                  mid_start;
        int                  exp_wr;    // -1: no hand-computed value
        bit                  exp_ovf;
        bit                  exp_cfg;
    } vec_t;

    typedef struct packed {
        logic [IDXW-1:0]  rg;
        logic [DSTW-1:0]  dst;
        logic [MP*DW-1:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   ack_dly = 0;
    int   val_dly = 1;
    bit   rnd_dly = 1'b0;
    int   req_cnt = 0;
    int   done_cnt = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    bit   m_ovf, m_cfg;
    int   m_words;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dword(input logic [DAW-1:0] a);
        return {a[9:0], 4'hD, a} ^ 32'h3C00_0000;
    endfunction

    // Region-level reference: entries of P words, capped at the destination depth.
    task automatic model(input vec_t v);
        longint s, f, n, ent, p, cnt, first;
        wr_t w;
        exp_q.delete();
        m_ovf = 1'b0; m_cfg = 1'b0; m_words = 0;
        for (int r = 0; r < NR; r++) begin
            if (v.en[r]) begin
                s = longint'(v.st[r]); f = longint'(v.fin[r]);
                if (f < s) begin
                    m_cfg = 1'b1;
                end else begin
                    p   = (v.pk[r] == 0) ? 1 : ((v.pk[r] > MP) ? MP : longint'(v.pk[r]));
                    n   = f - s + 1;
                    ent = (n + p - 1) / p;
                    if (ent > (1 << DSTW)) begin
                        m_ovf = 1'b1;
                        ent   = (1 << DSTW);
                    end
                    for (longint e = 0; e < ent; e++) begin
                        first = s + e * p;
                        cnt   = (n - e * p < p) ? (n - e * p) : p;
                        w.rg   = IDXW'(r);
                        w.dst  = DSTW'(e);
                        w.data = '0;
                        for (int j = 0; j < cnt; j++)
                            w.data[j*DW +: DW] = dword(DAW'(first + j));
                        exp_q.push_back(w);
                        m_words += int'(cnt);
                    end
                end
            end
        end
    endtask

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name = nm; v.en = '0; v.st = '0; v.fin = '0; v.pk = '0;
        v.ack_dly = 0; v.val_dly = 1; v.mid_start = 1'b0;
        v.exp_wr = -1; v.exp_ovf = 1'b0; v.exp_cfg = 1'b0;
        return v;
    endfunction

    function automatic vec_t with_reg(input vec_t vi, input int r, input logic [DAW-1:0] s,
                                      input logic [DAW-1:0] f, input logic [PW-1:0] p);
        vec_t v = vi;
        v.en[r] = 1'b1; v.st[r] = s; v.fin[r] = f; v.pk[r] = p;
        return v;
    endfunction

    // Capture every destination write.
    always @(negedge clk) begin
        if (general_rst_n_i && wr_en_o) got_q.push_back({wr_region_o, wr_addr_o, wr_data_o});
        if (general_rst_n_i && done_o) done_cnt++;
    end

    // DRAM responder: one request at a time, delayed ack then delayed data.
    initial begin : responder
        logic [DAW-1:0] a;
        int ad, vd;
        dram_rd_ack_i = 1'b0; dram_rd_valid_i = 1'b0; dram_rd_data_i = '0;
        forever begin
            @(negedge clk);
            dram_rd_ack_i = 1'b0; dram_rd_valid_i = 1'b0;
            if (general_rst_n_i && dram_rd_req_o) begin
                a  = dram_rd_addr_o;
                ad = rnd_dly ? int'($urandom_range(0, 3)) : ack_dly;
                vd = rnd_dly ? int'($urandom_range(1, 3)) : val_dly;
                for (int i = 0; i < ad; i++) begin
                    @(negedge clk);
                    chk("req_held", 256'({dram_rd_req_o, dram_rd_addr_o}), 256'({1'b1, a}));
                end
                dram_rd_ack_i = 1'b1;
                req_cnt++;
                @(negedge clk);
                dram_rd_ack_i = 1'b0;
                if (general_rst_n_i) chk("req_drop_after_ack", 256'(dram_rd_req_o), 256'(0));
                for (int i = 1; i < vd; i++) @(negedge clk);
                dram_rd_valid_i = 1'b1;
                dram_rd_data_i  = dword(a);
            end
        end
    end

    task automatic apply_cfg(input vec_t v);
        region_en_i          = v.en;
        region_start_addr_i  = v.st;
        region_finish_addr_i = v.fin;
        region_pack_i        = v.pk;
    endtask

    task automatic run_pass(input vec_t v, input bit lat_chk);
        bit seen = 1'b0;
        model(v);
        got_q.delete(); done_cnt = 0; req_cnt = 0;
        @(negedge clk);
        apply_cfg(v);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (lat_chk) begin
            chk({v.name, " select_cycle"}, 256'({busy_o, dram_rd_req_o}), 256'(2'b10));
            @(negedge clk);
            chk({v.name, " first_req_latency"}, 256'(dram_rd_req_o), 256'(1));
        end
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                start_i = (v.mid_start && cyc == 6) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        start_i = 1'b0;
        chk({v.name, " done_seen"}, 256'(seen), 256'(1));
        if (seen) begin
            start_i = 1'b1;          // pulse during the DONE cycle must be ignored
            @(negedge clk);
            start_i = 1'b0;
            chk({v.name, " busy_after_done"}, 256'({busy_o, done_o}), 256'(0));
            @(negedge clk);
            chk({v.name, " done_start_ignored"}, 256'(busy_o), 256'(0));
        end
        repeat (3) @(negedge clk);
        chk({v.name, " done_pulses"}, 256'(done_cnt), 256'(1));
        chk({v.name, " write_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        if (v.exp_wr >= 0) begin
            chk({v.name, " write_count_tbl"}, 256'(got_q.size()), 256'(v.exp_wr));
            chk({v.name, " flags_tbl"}, 256'({overflow_o, cfg_err_o}), 256'({v.exp_ovf, v.exp_cfg}));
        end
        chk({v.name, " flags"}, 256'({overflow_o, cfg_err_o}), 256'({m_ovf, m_cfg}));
        chk({v.name, " dram_reads"}, 256'(req_cnt), 256'(m_words));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({v.name, " wr_region"}, 256'(got_q[i].rg), 256'(exp_q[i].rg));
            chk({v.name, " wr_addr"}, 256'(got_q[i].dst), 256'(exp_q[i].dst));
            chk({v.name, " wr_data"}, 256'(got_q[i].data), 256'(exp_q[i].data));
        end
    endtask

    initial begin : main
        vec_t v;
        int   n_before;
        general_rst_n_i = 1'b0; start_i = 1'b0;
        apply_cfg(blank("none"));

        // Directed table: {configuration, delays, expected write count and flags}.
        tbl[0] = with_reg(blank("t0_p1"), 0, 18'h10, 18'h13, 3'd1);
        tbl[0].ack_dly = 1; tbl[0].exp_wr = 4;
        tbl[1] = with_reg(blank("t1_p4"), 1, 18'h20, 18'h26, 3'd4);
        tbl[1].exp_wr = 2;
        v = with_reg(blank("t2_all"), 0, 18'h100, 18'h102, 3'd1);
        v = with_reg(v, 1, 18'h200, 18'h207, 3'd2);
        v = with_reg(v, 2, 18'h300, 18'h2FF, 3'd1);
        tbl[2] = with_reg(v, 3, 18'h400, 18'h404, 3'd3);
        tbl[2].exp_wr = 9; tbl[2].exp_cfg = 1'b1;
        v = with_reg(blank("t3_ovf"), 0, 18'h50, 18'h55, 3'd1);
        tbl[3] = with_reg(v, 1, 18'h60, 18'h61, 3'd1);
        tbl[3].exp_wr = 6; tbl[3].exp_ovf = 1'b1;
        v = with_reg(blank("t4_slow"), 0, 18'h70, 18'h72, 3'd0);
        tbl[4] = with_reg(v, 3, 18'h80, 18'h86, 3'd7);
        tbl[4].ack_dly = 5; tbl[4].val_dly = 7; tbl[4].mid_start = 1'b1; tbl[4].exp_wr = 5;
        v = with_reg(blank("t5_top"), 0, 18'h3FFFD, 18'h3FFFF, 3'd2);
        tbl[5] = with_reg(v, 1, 18'h5, 18'h5, 3'd4);
        tbl[5].exp_wr = 3;
        tbl[6] = blank("t6_none");
        tbl[6].exp_wr = 0;

        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", 256'({dram_rd_req_o, dram_rd_addr_o, wr_en_o, wr_region_o, wr_addr_o,
                                busy_o, done_o, overflow_o, cfg_err_o}), 256'(0));
        chk("reset_wr_data", 256'(wr_data_o), 256'(0));
        general_rst_n_i = 1'b1;

        for (int i = 0; i < 7; i++) begin
            rnd_dly = 1'b0; ack_dly = tbl[i].ack_dly; val_dly = tbl[i].val_dly;
            run_pass(tbl[i], i == 0);
        end

        // Random passes against the region-level model.
        rnd_dly = 1'b1;
        for (int t = 0; t < 25; t++) begin
            v = blank($sformatf("rnd%0d", t));
            for (int r = 0; r < NR; r++) begin
                logic [DAW-1:0] s, f;
                s = DAW'($urandom_range(0, 32'h3FFF0));
                if ($urandom_range(0, 5) == 0) s = DAW'(32'h3FFFF - $urandom_range(0, 5));
                f = (s > DAW'(32'h3FFFF - 9)) ? 18'h3FFFF : s + DAW'($urandom_range(0, 9));
                if ($urandom_range(0, 7) == 0 && s != '0) f = s - 18'd1;
                v.st[r] = s; v.fin[r] = f; v.pk[r] = PW'($urandom_range(0, 7));
                v.en[r] = ($urandom_range(0, 3) != 0);
            end
            run_pass(v, 1'b0);
        end

        // Reset while waiting for read data aborts the pass cleanly.
        rnd_dly = 1'b0; ack_dly = 0; val_dly = 3;
        got_q.delete(); req_cnt = 0;
        v = with_reg(blank("rst_abort"), 0, 18'h10, 18'h1F, 3'd1);
        @(negedge clk);
        apply_cfg(v);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 200 && req_cnt < 2; c++) @(negedge clk);
        chk("rst_reach_second_req", 256'(req_cnt), 256'(2));
        @(negedge clk);
        chk("rst_in_wait", 256'({busy_o, dram_rd_req_o}), 256'(2'b10));
        general_rst_n_i = 1'b0;
        @(negedge clk);
        chk("rst_abort_ctrl", 256'({dram_rd_req_o, dram_rd_addr_o, wr_en_o, wr_region_o, wr_addr_o,
                                    busy_o, done_o, overflow_o, cfg_err_o}), 256'(0));
        chk("rst_abort_wr_data", 256'(wr_data_o), 256'(0));
        n_before = got_q.size();
        general_rst_n_i = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_no_late_write", 256'(got_q.size()), 256'(n_before));
        chk("rst_idle", 256'({busy_o, dram_rd_req_o}), 256'(0));
        ack_dly = 1; val_dly = 1;
        tbl[0].name = "post_rst";
        run_pass(tbl[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
